// File: rtl/load_store_unit.sv
// Load/store unit: turns single-cycle core memory accesses into a ready/ack bus transaction.
// Optional bus-timeout abort path is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              align_err,
    output logic              timeout_err,
    input  logic              clr_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [2:0]  funct3_r;
    logic [1:0]  offset_r;
    logic        legal_s;
    logic        aligned_s;
    logic        issue_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_r;
`else
    assign timeout_err = 1'b0;
`endif

    // Selects the byte/halfword lane of the returned word and extends it.
    function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  format_load = {{24{b[7]}}, b};
            3'b001:  format_load = {{16{h[15]}}, h};
            3'b100:  format_load = {24'h000000, b};
            3'b101:  format_load = {16'h0000, h};
            default: format_load = word;
        endcase
    endfunction

    // Legality and alignment decode of the access presented by the core.
    always_comb begin
        legal_s   = 1'b0;
        aligned_s = 1'b1;
        case (funct3)
            3'b000: begin
                legal_s   = 1'b1;
                aligned_s = 1'b1;
            end
            3'b001: begin
                legal_s   = 1'b1;
                aligned_s = ~addr[0];
            end
            3'b010: begin
                legal_s   = 1'b1;
                aligned_s = (addr[1:0] == 2'b00);
            end
            3'b100: begin
                legal_s   = ~req_we;
                aligned_s = 1'b1;
            end
            3'b101: begin
                legal_s   = ~req_we;
                aligned_s = ~addr[0];
            end
            default: begin
                legal_s   = 1'b0;
                aligned_s = 1'b1;
            end
        endcase
    end

    // Byte-enable generation and lane replication of store data.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = 32'h0000_0000;
        if (req_we) begin
            case (funct3)
                3'b000: begin
                    be_s    = 4'b0001 << addr[1:0];
                    wdata_s = {4{wdata[7:0]}};
                end
                3'b001: begin
                    be_s    = 4'b0011 << addr[1:0];
                    wdata_s = {2{wdata[15:0]}};
                end
                default: begin
                    be_s    = 4'b1111;
                    wdata_s = wdata;
                end
            endcase
        end else begin
            be_s    = 4'b1111;
            wdata_s = 32'h0000_0000;
        end
    end

    assign issue_s = req_valid & legal_s & aligned_s;

    // Stall is combinational so the core is frozen in the same cycle the request appears.
    assign stall = ((state_r == ST_IDLE) & issue_s) | (state_r == ST_BUSY);

    // Transaction FSM with registered bus outputs, load data and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            funct3_r    <= 3'b000;
            offset_r    <= 2'b00;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= 4'b0000;
            bus_wdata   <= 32'h0000_0000;
            rdata       <= 32'h0000_0000;
            align_err   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            timeout_err <= 1'b0;
            cnt_r       <= 8'd0;
`endif
        end else begin
            // Clear first so that an error set later in this block takes priority.
            if (clr_err) begin
                align_err   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                timeout_err <= 1'b0;
`endif
            end
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        funct3_r  <= funct3;
                        offset_r  <= addr[1:0];
                        bus_req   <= 1'b1;
                        bus_we    <= req_we;
                        bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        bus_be    <= be_s;
                        bus_wdata <= wdata_s;
                        state_r   <= ST_BUSY;
                    end else if (req_valid) begin
                        align_err <= 1'b1;
                        rdata     <= 32'h0000_0000;
                    end
                end
                ST_BUSY: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            rdata <= format_load(funct3_r, offset_r, bus_rdata);
                        end
                        state_r <= ST_DONE;
                    end else begin
`ifdef LSU_TIMEOUT_EN
                        if (cnt_r == TIMEOUT_LAST) begin
                            bus_req     <= 1'b0;
                            timeout_err <= 1'b1;
                            rdata       <= 32'h0000_0000;
                            state_r     <= ST_DONE;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
`else
                        state_r <= ST_BUSY;
`endif
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
`ifdef LSU_TIMEOUT_EN
                    cnt_r   <= 8'd0;
`endif
                end
                default: begin
                    bus_req <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit; timeout scenario depends on LSU_TIMEOUT_EN.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, clr_err, bus_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, bus_rdata;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic        stall, align_err, timeout_err, bus_req, bus_we;
    logic [3:0]  bus_be;

    int tests_run = 0;
    int fails = 0;

    load_store_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .align_err(align_err), .timeout_err(timeout_err),
        .clr_err(clr_err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Reference model: rules of the access, written with plain arithmetic.
    function automatic logic m_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 <= 3'd2);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic m_aligned(input logic [2:0] f3, input logic [31:0] a);
        int size;
        size = 1 << f3[1:0];
        return (a % size) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int size, mask;
        if (!we) return 4'hF;
        size = 1 << f3[1:0];
        mask = ((1 << size) - 1) << (a % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
        logic [31:0] v, b, h;
        v = word >> (8 * (a % 4));
        b = v & 32'hFF;
        h = v & 32'hFFFF;
        if (f3 == 3'd0) return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
        if (f3 == 3'd1) return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
        if (f3 == 3'd4) return b;
        if (f3 == 3'd5) return h;
        return word;
    endfunction

    // Drives one core request and plays the memory side; waits<0 never acks.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int waits, input logic [31:0] rword,
                              output int stall_cnt, output int busy_cnt, output logic [31:0] rd,
                              output logic saw_req, output logic [31:0] s_addr, output logic [3:0] s_be,
                              output logic [31:0] s_wdata, output logic s_we, output logic stable,
                              output logic hung);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
        stall_cnt = 0; busy_cnt = 0; saw_req = 1'b0; stable = 1'b1; hung = 1'b1;
        rd = 32'h0; s_addr = 32'h0; s_be = 4'h0; s_wdata = 32'h0; s_we = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (stall) stall_cnt++;
            if (bus_req) begin
                if (busy_cnt == 0) begin
                    saw_req = 1'b1; s_addr = bus_addr; s_be = bus_be; s_wdata = bus_wdata; s_we = bus_we;
                end else if ({bus_addr, bus_be, bus_wdata, bus_we} !== {s_addr, s_be, s_wdata, s_we}) begin
                    stable = 1'b0;
                end
                if (busy_cnt == waits) begin
                    bus_ack = 1'b1; bus_rdata = rword;
                end
                busy_cnt++;
            end else if (!stall) begin
                rd = rdata; hung = 1'b0;
                break;
            end
            @(negedge clk);
            bus_ack = 1'b0; bus_rdata = $urandom;
        end
        @(negedge clk);
        req_valid = 1'b0; bus_ack = 1'b0;
    endtask

    int sc, bc;
    logic [31:0] rd, sa, swd;
    logic [3:0] sbe;
    logic sreq, swe, stab, hung;

    task automatic test_reset;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'd0; addr = 32'h0;
        wdata = 32'h0; clr_err = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        tests_run++;
        if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, align_err, timeout_err, stall} !== 104'h0) begin
            fails++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wd=%h rd=%h ae=%b te=%b st=%b want all 0",
                     bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, align_err, timeout_err, stall);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_store_word;
        run_access(1'b1, 3'd2, 32'h104, 32'hCAFE_BABE, 0, 32'h0, sc, bc, rd, sreq, sa, sbe, swd, swe, stab, hung);
        tests_run++;
        if (sc !== 2) begin fails++; $display("FAIL sw_stall: got %0d want 2", sc); end
        tests_run++;
        if ({sa, sbe, swd, swe} !== {32'h104, 4'b1111, 32'hCAFE_BABE, 1'b1}) begin
            fails++; $display("FAIL sw_bus: got addr=%h be=%b wd=%h we=%b want 104 1111 cafebabe 1", sa, sbe, swd, swe);
        end
    endtask

    task automatic test_store_byte;
        run_access(1'b1, 3'd0, 32'h203, 32'h0000_00A5, 1, 32'h0, sc, bc, rd, sreq, sa, sbe, swd, swe, stab, hung);
        tests_run++;
        if ({sa, sbe, swd} !== {32'h200, 4'b1000, 32'hA5A5_A5A5}) begin
            fails++; $display("FAIL sb_bus: got addr=%h be=%b wd=%h want 200 1000 a5a5a5a5", sa, sbe, swd);
        end
        tests_run++;
        if (sc !== 3) begin fails++; $display("FAIL sb_stall: got %0d want 3", sc); end
    endtask

    task automatic test_loads;
        run_access(1'b0, 3'd0, 32'h301, 32'h0, 0, 32'h1234_80FF, sc, bc, rd, sreq, sa, sbe, swd, swe, stab, hung);
        tests_run++;
        if (rd !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb: got %h want ffffff80", rd); end
        tests_run++;
        if ({sa, sbe, swe} !== {32'h300, 4'b1111, 1'b0}) begin
            fails++; $display("FAIL lb_bus: got addr=%h be=%b we=%b want 300 1111 0", sa, sbe, swe);
        end
        run_access(1'b0, 3'd4, 32'h301, 32'h0, 0, 32'h1234_80FF, sc, bc, rd, sreq, sa, sbe, swd, swe, stab, hung);
        tests_run++;
        if (rd !== 32'h0000_0080) begin fails++; $display("FAIL lbu: got %h want 00000080", rd); end
        run_access(1'b0, 3'd1, 32'h302, 32'h0, 0, 32'h1234_80FF, sc, bc, rd, sreq, sa, sbe, swd, swe, stab, hung);
        tests_run++;
        if (rd !== 32'h0000_1234) begin fails++; $display("FAIL lh: got %h want 00001234", rd); end
        run_access(1'b0, 3'd5, 32'h300, 32'h0, 0, 32'h1234_80FF, sc, bc, rd, sreq, sa, sbe, swd, swe, stab, hung);
        tests_run++;
        if (rd !== 32'h0000_80FF) begin fails++; $display("FAIL lhu: got %h want 000080ff", rd); end
    endtask

    task automatic test_misaligned;
        run_access(1'b0, 3'd2, 32'h102, 32'h0, 0, 32'h0, sc, bc, rd, sreq, sa, sbe, swd, swe, stab, hung);
        tests_run++;
        if ({sreq, sc} !== {1'b0, 32'd0}) begin fails++; $display("FAIL lw_mis_nobus: got req=%b stall=%0d want 0 0", sreq, sc); end
        tests_run++;
        if ({align_err, rdata} !== {1'b1, 32'h0}) begin
            fails++; $display("FAIL lw_mis_err: got ae=%b rd=%h want 1 00000000", align_err, rdata);
        end
        clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
        tests_run++;
        if (align_err !== 1'b0) begin fails++; $display("FAIL clr_err: got %b want 0", align_err); end
        // Illegal store size must be rejected without touching the bus.
        run_access(1'b1, 3'd4, 32'h100, 32'h55, 0, 32'h0, sc, bc, rd, sreq, sa, sbe, swd, swe, stab, hung);
        tests_run++;
        if ({sreq, align_err} !== 2'b01) begin fails++; $display("FAIL st_illegal: got req=%b ae=%b want 0 1", sreq, align_err); end
        // Coincident clear and new error: the new error must survive.
        clr_err = 1'b1;
        run_access(1'b1, 3'd1, 32'h101, 32'h55, 0, 32'h0, sc, bc, rd, sreq, sa, sbe, swd, swe, stab, hung);
        clr_err = 1'b0;
        tests_run++;
        if (align_err !== 1'b1) begin fails++; $display("FAIL set_wins: got %b want 1", align_err); end
        clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    endtask

    task automatic test_wait_states;
        run_access(1'b0, 3'd2, 32'h400, 32'h0, 3, 32'hDEAD_BEEF, sc, bc, rd, sreq, sa, sbe, swd, swe, stab, hung);
        tests_run++;
        if ({sc, rd} !== {32'd5, 32'hDEAD_BEEF}) begin fails++; $display("FAIL lw_wait3: got stall=%0d rd=%h want 5 deadbeef", sc, rd); end
        tests_run++;
        if (stab !== 1'b1) begin fails++; $display("FAIL bus_stable: got %b want 1", stab); end
    endtask

    task automatic test_timeout;
`ifdef LSU_TIMEOUT_EN
        run_access(1'b0, 3'd2, 32'h500, 32'h0, -1, 32'h0, sc, bc, rd, sreq, sa, sbe, swd, swe, stab, hung);
        tests_run++;
        if ({hung, bc, sc, rd} !== {1'b0, 32'd15, 32'd16, 32'h0}) begin
            fails++; $display("FAIL timeout: got hung=%b busy=%0d stall=%0d rd=%h want 0 15 16 0", hung, bc, sc, rd);
        end
        tests_run++;
        if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b want 1", timeout_err); end
        clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
        tests_run++;
        if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_clr: got %b want 0", timeout_err); end
`else
        run_access(1'b0, 3'd2, 32'h500, 32'h0, 30, 32'h0BAD_F00D, sc, bc, rd, sreq, sa, sbe, swd, swe, stab, hung);
        tests_run++;
        if ({bc, sc, rd, timeout_err} !== {32'd31, 32'd32, 32'h0BAD_F00D, 1'b0}) begin
            fails++; $display("FAIL long_wait: got busy=%0d stall=%0d rd=%h te=%b want 31 32 0badf00d 0", bc, sc, rd, timeout_err);
        end
`endif
    endtask

    task automatic test_ack_ignored;
        logic [31:0] prev;
        prev = rdata;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        tests_run++;
        if ({bus_req, stall, rdata} !== {2'b00, prev}) begin
            fails++; $display("FAIL ack_idle: got req=%b stall=%b rd=%h want 0 0 %h", bus_req, stall, rdata, prev);
        end
    endtask

    task automatic test_random;
        logic we, bad;
        logic [2:0] f3;
        logic [31:0] a, wd, rw, exp_rd;
        logic exp_ae;
        int waits;
        exp_rd = rdata;
        exp_ae = align_err;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom); f3 = 3'($urandom); a = $urandom & 32'h0000_FFFF;
            wd = $urandom; rw = $urandom; waits = $urandom_range(0, 3);
            bad = !m_legal(we, f3) || !m_aligned(f3, a);
            run_access(we, f3, a, wd, waits, rw, sc, bc, rd, sreq, sa, sbe, swd, swe, stab, hung);
            if (bad) begin
                exp_ae = 1'b1; exp_rd = 32'h0;
                tests_run++;
                if ({sreq, sc, rdata} !== {1'b0, 32'd0, exp_rd}) begin
                    fails++; $display("FAIL rnd_bad[%0d]: got req=%b stall=%0d rd=%h want 0 0 0", i, sreq, sc, rdata);
                end
            end else begin
                if (!we) exp_rd = m_load(f3, a, rw);
                tests_run++;
                if ({sc, rd, sa, sbe, stab} !== {waits + 2, exp_rd, a & 32'hFFFF_FFFC, m_be(we, f3, a), 1'b1}) begin
                    fails++;
                    $display("FAIL rnd_ok[%0d]: we=%b f3=%0d a=%h got stall=%0d rd=%h addr=%h be=%b stable=%b want %0d %h %h %b 1",
                             i, we, f3, a, sc, rd, sa, sbe, stab, waits + 2, exp_rd, a & 32'hFFFF_FFFC, m_be(we, f3, a));
                end
                if (we) begin
                    tests_run++;
                    if (swd !== m_wdata(f3, wd)) begin fails++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, swd, m_wdata(f3, wd)); end
                end
            end
            tests_run++;
            if (align_err !== exp_ae) begin fails++; $display("FAIL rnd_ae[%0d]: got %b want %b", i, align_err, exp_ae); end
        end
    endtask

    task automatic test_reset_mid_busy;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd2; addr = 32'h600; wdata = 32'h1111_2222;
        @(negedge clk);
        tests_run++;
        if (bus_req !== 1'b1) begin fails++; $display("FAIL rst_pre_busy: got %b want 1", bus_req); end
        #2;
        reset = 1'b0; req_valid = 1'b0;
        #1;
        tests_run++;
        if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, align_err, timeout_err, stall} !== 104'h0) begin
            fails++;
            $display("FAIL rst_mid_busy: got req=%b we=%b addr=%h be=%b wd=%h rd=%h ae=%b te=%b st=%b want all 0",
                     bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, align_err, timeout_err, stall);
        end
        @(negedge clk);
        reset = 1'b1;
        run_access(1'b0, 3'd2, 32'h700, 32'h0, 0, 32'h4242_4242, sc, bc, rd, sreq, sa, sbe, swd, swe, stab, hung);
        tests_run++;
        if ({sc, rd} !== {32'd2, 32'h4242_4242}) begin fails++; $display("FAIL post_rst: got stall=%0d rd=%h want 2 42424242", sc, rd); end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_byte();
        test_loads();
        test_misaligned();
        test_wait_states();
        test_timeout();
        test_ack_ignored();
        test_random();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
